// File: rtl/i2s_adc_rx_if.sv
// FIFO-side interface of the I2S ADC receiver.
//   fifo_wrfull : FIFO full flag, write-clock domain (slave -> master)
//   fifo_wrreq  : one-cycle write strobe             (master -> slave)
//   fifo_data   : {right, left} raw samples          (master -> slave)
//   drop_count  : saturating dropped-frame counter   (master -> slave)
interface i2s_adc_rx_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic                      fifo_wrfull;
  logic                      fifo_wrreq;
  logic [2*SAMPLE_WIDTH-1:0] fifo_data;
  logic [15:0]               drop_count;

  modport master (
    input  fifo_wrfull,
    output fifo_wrreq,
    output fifo_data,
    output drop_count
  );

  modport slave (
    output fifo_wrfull,
    input  fifo_wrreq,
    input  fifo_data,
    input  drop_count
  );
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S master receiver for an external stereo ADC.
// Generates BCK (clock/2) and LRCK (clock/128), holds the ADC in power-down
// for PD_CYCLES after reset, deserialises MSB-first left/right samples and
// writes one {R,L} word per frame into a FIFO.
//   clock    : audio clock, 128 x Fs
//   reset    : synchronous, active-high
//   ADC_PD   : ADC power-down, active low
//   ADC_BCK  : bit clock
//   ADC_LRCK : frame clock, 0 = left, 1 = right
//   ADC_DATA : serial data from the ADC
//   fifo     : FIFO write port (wrfull, wrreq, data, drop_count)
module i2s_adc_rx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int PD_CYCLES    = 1024
) (
  input  logic clock,
  input  logic reset,
  output logic ADC_PD,
  output logic ADC_BCK,
  output logic ADC_LRCK,
  input  logic ADC_DATA,
  i2s_adc_rx_if.master fifo
);

  localparam int         PD_W     = $clog2(PD_CYCLES + 1);
  localparam logic [PD_W-1:0] PD_LAST = PD_W'(PD_CYCLES - 1);
  localparam logic [4:0] LAST_BIT = 5'(SAMPLE_WIDTH);

  typedef enum logic {
    ST_PD  = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PD_W-1:0]           pd_cnt;
  logic [6:0]                cnt;
  logic                      capture_en;
  logic [SAMPLE_WIDTH-1:0]   shift_q;
  logic [SAMPLE_WIDTH-1:0]   left_q;
  logic [2*SAMPLE_WIDTH-1:0] data_q;
  logic                      wrreq_q;
  logic [15:0]               drop_cnt;

  logic [4:0]              slot_bit;
  logic                    cap_edge;
  logic                    last_edge;
  logic [SAMPLE_WIDTH-1:0] shift_nxt;

  assign slot_bit  = cnt[5:1];
  // Slot bit 0 is the I2S one-bit delay; bits past the sample are padding.
  assign cap_edge  = capture_en && cnt[0] && (slot_bit != 5'd0) && (slot_bit <= LAST_BIT);
  assign last_edge = cap_edge && (slot_bit == LAST_BIT);
  assign shift_nxt = {shift_q[SAMPLE_WIDTH-2:0], ADC_DATA};

  assign ADC_BCK         = cnt[0];
  assign ADC_LRCK        = cnt[6];
  assign fifo.fifo_wrreq = wrreq_q;
  assign fifo.fifo_data  = data_q;
  assign fifo.drop_count = drop_cnt;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_PD && pd_cnt == PD_LAST) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_PD;
      pd_cnt     <= '0;
      ADC_PD     <= 1'b0;
      cnt        <= '0;
      capture_en <= 1'b0;
      shift_q    <= '0;
      left_q     <= '0;
      data_q     <= '0;
      wrreq_q    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q <= state_d;
      wrreq_q <= 1'b0;
      if (state_q == ST_PD) begin
        if (pd_cnt == PD_LAST) begin
          ADC_PD <= 1'b1;
        end else begin
          pd_cnt <= pd_cnt + 1'b1;
        end
      end else begin
        cnt <= cnt + 7'd1;
        // Capture starts with the first full frame after PD release.
        if (cnt == 7'd127) begin
          capture_en <= 1'b1;
        end
        if (cap_edge) begin
          shift_q <= shift_nxt;
        end
        if (last_edge) begin
          if (!cnt[6]) begin
            left_q <= shift_nxt;
          end else if (!fifo.fifo_wrfull) begin
            data_q  <= {shift_nxt, left_q};
            wrreq_q <= 1'b1;
          end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed testbench for i2s_adc_rx with a pin-level I2S ADC model.
module tb_i2s_adc_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ADC_DATA = 1'b0;
  logic ADC_PD, ADC_BCK, ADC_LRCK;

  i2s_adc_rx_if #(.SAMPLE_WIDTH(24)) fifo_if ();

  i2s_adc_rx #(.SAMPLE_WIDTH(24), .PD_CYCLES(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .ADC_PD   (ADC_PD),
    .ADC_BCK  (ADC_BCK),
    .ADC_LRCK (ADC_LRCK),
    .ADC_DATA (ADC_DATA),
    .fifo     (fifo_if.master)
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [23:0] l_word = 24'h123456;
  logic [23:0] r_word = 24'hABCDEF;
  logic        pad    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: follows BCK/LRCK pins, drives a new bit after each BCK rise.
  initial begin
    int   idx;
    logic pl, pb;
    logic [23:0] w;
    idx = 0; pl = 1'b0; pb = 1'b0;
    forever begin
      @(negedge clock);
      if (ADC_LRCK !== pl) idx = 0;
      if (ADC_BCK === 1'b1 && pb === 1'b0) begin
        w = ADC_LRCK ? r_word : l_word;
        if (idx == 0 || idx > 24) ADC_DATA = pad;
        else                      ADC_DATA = w[24-idx];
        idx++;
      end
      pl = ADC_LRCK;
      pb = ADC_BCK;
    end
  end

  task automatic wait_wrreq(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (fifo_if.fifo_wrreq) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Releases reset and measures negedges until ADC_PD rises.
  task automatic power_up(input string tag);
    int n, bad, wr;
    n = 0; bad = 0; wr = 0;
    reset = 1'b0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      if (fifo_if.fifo_wrreq) wr++;
      if (ADC_PD) break;
      if (ADC_BCK || ADC_LRCK) bad++;
    end
    check({tag, "_pd_len"}, n, 16);
    check({tag, "_pd_clk_low"}, bad, 0);
    check({tag, "_pd_no_wr"}, wr, 0);
  endtask

  initial begin
    int cyc, wr;
    fifo_if.fifo_wrfull = 1'b0;

    // Reset state
    repeat (5) @(negedge clock);
    check("rst_pd", ADC_PD, 0);
    check("rst_bck", ADC_BCK, 0);
    check("rst_lrck", ADC_LRCK, 0);
    check("rst_wrreq", fifo_if.fifo_wrreq, 0);
    check("rst_data", fifo_if.fifo_data, 0);
    check("rst_drop", fifo_if.drop_count, 0);

    power_up("init");
    check("bck_c0", ADC_BCK, 0);
    @(negedge clock);
    check("bck_c1", ADC_BCK, 1);
    @(negedge clock);
    check("bck_c2", ADC_BCK, 0);

    // First write: first partial frame skipped, wrreq at cnt=114 of next frame
    wait_wrreq(300, cyc);
    check("first_wr_lat", cyc, 240);
    check("first_wr_lrck", ADC_LRCK, 1);
    check("first_wr_bck", ADC_BCK, 0);
    check("first_wr_data", fifo_if.fifo_data, 48'hABCDEF_123456);
    @(negedge clock);
    check("wr_one_cycle", fifo_if.fifo_wrreq, 0);
    check("data_stable", fifo_if.fifo_data, 48'hABCDEF_123456);
    wait_wrreq(200, cyc);
    check("second_wr_lat", cyc, 127);
    check("second_wr_data", fifo_if.fifo_data, 48'hABCDEF_123456);

    // Extreme values with padding/delay bits driven high
    l_word = 24'h800000; r_word = 24'h7FFFFF; pad = 1'b1;
    wait_wrreq(200, cyc);
    check("pad_wr_lat", cyc, 128);
    check("pad_wr_data", fifo_if.fifo_data, 48'h7FFFFF_800000);

    // wrfull pulse away from the evaluation edge is ignored
    l_word = 24'h123456; r_word = 24'hABCDEF; pad = 1'b0;
    repeat (30) @(negedge clock);
    fifo_if.fifo_wrfull = 1'b1;
    repeat (10) @(negedge clock);
    fifo_if.fifo_wrfull = 1'b0;
    wait_wrreq(200, cyc);
    check("glitch_wr_lat", cyc, 88);
    check("glitch_wr_data", fifo_if.fifo_data, 48'hABCDEF_123456);
    check("glitch_drop", fifo_if.drop_count, 0);

    // Three dropped frames
    l_word = 24'h000001; r_word = 24'hFFFFFE;
    fifo_if.fifo_wrfull = 1'b1;
    wr = 0;
    repeat (384) begin
      @(negedge clock);
      if (fifo_if.fifo_wrreq) wr++;
    end
    check("drop_no_wr", wr, 0);
    check("drop_count3", fifo_if.drop_count, 3);
    check("drop_data_held", fifo_if.fifo_data, 48'hABCDEF_123456);
    fifo_if.fifo_wrfull = 1'b0;
    wait_wrreq(200, cyc);
    check("resume_wr_lat", cyc, 128);
    check("resume_wr_data", fifo_if.fifo_data, 48'hFFFFFE_000001);

    // Saturation: counter preloaded near the top instead of 65k frames
    force dut.drop_cnt = 16'hFFFD;
    #1;
    release dut.drop_cnt;
    fifo_if.fifo_wrfull = 1'b1;
    repeat (384) @(negedge clock);
    check("drop_sat", fifo_if.drop_count, 16'hFFFF);
    fifo_if.fifo_wrfull = 1'b0;
    wait_wrreq(200, cyc);
    check("sat_resume_lat", cyc, 128);
    check("sat_hold", fifo_if.drop_count, 16'hFFFF);

    // Reset mid right slot (cnt=80)
    repeat (94) @(negedge clock);
    check("pre_rst_lrck", ADC_LRCK, 1);
    reset = 1'b1;
    wr = 0;
    repeat (3) begin
      @(negedge clock);
      if (fifo_if.fifo_wrreq) wr++;
    end
    check("midrst_no_wr", wr, 0);
    check("midrst_pd", ADC_PD, 0);
    check("midrst_data", fifo_if.fifo_data, 0);
    check("midrst_drop", fifo_if.drop_count, 0);
    power_up("restart");
    wait_wrreq(300, cyc);
    check("restart_wr_lat", cyc, 242);
    check("restart_wr_data", fifo_if.fifo_data, 48'hFFFFFE_000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
